lut_neuron_loader: RTL

Runtime-programmable truth-table neuron for the LogicNets layers. It accepts a serial configuration stream that writes a 2^IN_BITS-entry truth table into distributed RAM, then serves registered lookups with the same input-to-output mapping as a fixed neuron ROM. It sits between the configuration bus and a layer's neuron inputs, so trained tables can be swapped without resynthesis.

---
 rtl/lut_neuron_loader.sv | 82 ++++++++
 1 files changed

// File: rtl/lut_neuron_loader.sv
// lut_neuron_loader: serially loaded truth-table neuron with registered 1-cycle lookups.
// Optional LUT_CHECKSUM_EN adds ones_count, a popcount of cfg_data[0] over the current load.
module lut_neuron_loader #(
   parameter int IN_BITS  = 6,
   parameter int OUT_BITS = 1,
   localparam int DEPTH   = 2**IN_BITS
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                load_start,
   input  logic                cfg_valid,
   output logic                cfg_ready,
   input  logic [OUT_BITS-1:0] cfg_data,
   input  logic                cfg_last,
   input  logic                in_valid,
   output logic                in_ready,
   input  logic [IN_BITS-1:0]  in_data,
   output logic                out_valid,
   output logic [OUT_BITS-1:0] out_data,
   output logic                loaded,
   output logic                load_err
`ifdef LUT_CHECKSUM_EN
   ,
   output logic [IN_BITS:0]    ones_count
`endif
);
   typedef enum logic [1:0] {EMPTY, LOAD, RUN} state_t;
   state_t state;
   logic [IN_BITS-1:0] addr;
   logic [OUT_BITS-1:0] mem [DEPTH];
   logic cfg_acc;
   logic at_end;
   // a word arriving with load_start restarts the stream and is dropped
   assign cfg_acc = state == LOAD && cfg_valid && !load_start;
   assign at_end  = &addr;
   always_ff @(posedge clk)
      if (cfg_acc) mem[addr] <= cfg_data;
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         state     <= EMPTY;
         addr      <= '0;
         cfg_ready <= 1'b0;
         in_ready  <= 1'b0;
         out_valid <= 1'b0;
         out_data  <= '0;
         loaded    <= 1'b0;
         load_err  <= 1'b0;
      end else begin
         out_valid <= state == RUN && in_valid;
         if (state == RUN && in_valid) out_data <= mem[in_data];
         if (load_start) begin
            state     <= LOAD;
            addr      <= '0;
            cfg_ready <= 1'b1;
            in_ready  <= 1'b0;
            loaded    <= 1'b0;
            load_err  <= 1'b0;
         end else if (cfg_acc) begin
            if (cfg_last && at_end) begin
               state     <= RUN;
               cfg_ready <= 1'b0;
               in_ready  <= 1'b1;
               loaded    <= 1'b1;
               addr      <= '0;
            end else if (cfg_last || at_end) begin
               // early last, or a full table with no last: never wrap into entry 0
               state     <= EMPTY;
               cfg_ready <= 1'b0;
               load_err  <= 1'b1;
               addr      <= '0;
            end else begin
               addr <= addr + 1'b1;
            end
         end
      end
`ifdef LUT_CHECKSUM_EN
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) ones_count <= '0;
      else if (load_start) ones_count <= '0;
      else if (cfg_acc) ones_count <= ones_count + (IN_BITS+1)'(cfg_data[0]);
`endif
endmodule
